// File: rtl/elevator_car_drive.sv
// elevator_car_drive: car-side responder for the elevator controller.
// Runs timed one-floor travel and door cycles, and reports door, load,
// floor and fault status back to the controller.
// Optional feature: define CAR_DOOR_REVERSAL_EN so that obstruction during
// door closing reopens the door. Otherwise obstruction only extends the hold.
module elevator_car_drive #(
  parameter int unsigned TRAVEL_CYCLES    = 16,
  parameter int unsigned DOOR_MOVE_CYCLES = 4,
  parameter int unsigned DOOR_HOLD_CYCLES = 8,
  parameter int unsigned LOAD_LIMIT       = 200
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       move_up_i,
  input  logic       move_down_i,
  input  logic       open_door_i,
  input  logic       obstruction_i,
  input  logic [7:0] load_weight_i,
  output logic       door_closed_o,
  output logic       overload_o,
  output logic [1:0] floor_pos_o,
  output logic       at_floor_o,
  output logic       motor_up_o,
  output logic       motor_down_o,
  output logic       door_motor_open_o,
  output logic       door_motor_close_o,
  output logic       limit_hit_o,
  output logic       fault_o
);

  localparam int unsigned MaxA = (TRAVEL_CYCLES > DOOR_MOVE_CYCLES) ?
                                 TRAVEL_CYCLES : DOOR_MOVE_CYCLES;
  localparam int unsigned MaxP = (MaxA > DOOR_HOLD_CYCLES) ? MaxA : DOOR_HOLD_CYCLES;
  // The counter only ever reaches MaxP-1.
  localparam int unsigned CntW = (MaxP > 1) ? $clog2(MaxP) : 1;

  localparam logic [CntW-1:0] TravelLast = CntW'(TRAVEL_CYCLES - 1);
  localparam logic [CntW-1:0] MoveLast   = CntW'(DOOR_MOVE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(DOOR_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StTravelUp,
    StTravelDown,
    StDoorOpening,
    StDoorHold,
    StDoorClosing,
    StFault
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      floor_q, floor_d;
  logic            overload_q;
  logic            limit_hit_q, limit_hit_d;
  logic            reopen;

`ifdef CAR_DOOR_REVERSAL_EN
  assign reopen = overload_q | open_door_i | obstruction_i;
`else
  assign reopen = overload_q | open_door_i;
`endif

  // Next-state, counter, floor and rejection-pulse logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    floor_d     = floor_q;
    limit_hit_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (move_up_i && move_down_i) begin
          state_d = StFault;
        end else if (open_door_i) begin
          state_d = StDoorOpening;
        end else if (move_up_i) begin
          if (floor_q != 2'd3 && !overload_q) state_d = StTravelUp;
          else                                limit_hit_d = 1'b1;
        end else if (move_down_i) begin
          if (floor_q != 2'd0 && !overload_q) state_d = StTravelDown;
          else                                limit_hit_d = 1'b1;
        end
      end
      StTravelUp: begin
        if (cnt_q == TravelLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          floor_d = floor_q + 2'd1;
        end
      end
      StTravelDown: begin
        if (cnt_q == TravelLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          floor_d = floor_q - 2'd1;
        end
      end
      StDoorOpening: begin
        if (cnt_q == MoveLast) begin
          state_d = StDoorHold;
          cnt_d   = '0;
        end
      end
      StDoorHold: begin
        // Any request to keep the door open restarts the dwell.
        if (open_door_i || obstruction_i || overload_q) begin
          cnt_d = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StDoorClosing;
          cnt_d   = '0;
        end
      end
      StDoorClosing: begin
        if (reopen) begin
          state_d = StDoorOpening;
          cnt_d   = '0;
        end else if (cnt_q == MoveLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StFault: begin
        cnt_d = '0;
      end
      default: begin
        state_d = StFault;
        cnt_d   = '0;
      end
    endcase
  end

  // State, status registers and Moore outputs registered from the next state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q            <= StIdle;
      cnt_q              <= '0;
      floor_q            <= 2'd0;
      overload_q         <= 1'b0;
      limit_hit_q        <= 1'b0;
      door_closed_o      <= 1'b1;
      at_floor_o         <= 1'b1;
      motor_up_o         <= 1'b0;
      motor_down_o       <= 1'b0;
      door_motor_open_o  <= 1'b0;
      door_motor_close_o <= 1'b0;
      fault_o            <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      floor_q            <= floor_d;
      overload_q         <= (32'(load_weight_i) > LOAD_LIMIT);
      limit_hit_q        <= limit_hit_d;
      door_closed_o      <= (state_d == StIdle) || (state_d == StFault);
      at_floor_o         <= !((state_d == StTravelUp) || (state_d == StTravelDown));
      motor_up_o         <= (state_d == StTravelUp);
      motor_down_o       <= (state_d == StTravelDown);
      door_motor_open_o  <= (state_d == StDoorOpening);
      door_motor_close_o <= (state_d == StDoorClosing);
      fault_o            <= (state_d == StFault);
    end
  end

  assign overload_o  = overload_q;
  assign floor_pos_o = floor_q;
  assign limit_hit_o = limit_hit_q;

endmodule

// File: tb/tb_elevator_car_drive.sv
module tb_elevator_car_drive;

  logic       clk = 1'b0;
  logic       reset, move_up, move_down, open_door, obstruction;
  logic [7:0] load_weight;
  logic       door_closed, overload, at_floor, motor_up, motor_down;
  logic       door_motor_open, door_motor_close, limit_hit, fault;
  logic [1:0] floor_pos;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  elevator_car_drive dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .move_up_i          (move_up),
    .move_down_i        (move_down),
    .open_door_i        (open_door),
    .obstruction_i      (obstruction),
    .load_weight_i      (load_weight),
    .door_closed_o      (door_closed),
    .overload_o         (overload),
    .floor_pos_o        (floor_pos),
    .at_floor_o         (at_floor),
    .motor_up_o         (motor_up),
    .motor_down_o       (motor_down),
    .door_motor_open_o  (door_motor_open),
    .door_motor_close_o (door_motor_close),
    .limit_hit_o        (limit_hit),
    .fault_o            (fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_door_closed"}, 8'(door_closed), 8'd1);
    chk({tag, "_at_floor"},    8'(at_floor),    8'd1);
    chk({tag, "_floor"},       8'(floor_pos),   8'd0);
    chk({tag, "_motors"}, 8'({motor_up, motor_down, door_motor_open, door_motor_close}), 8'd0);
    chk({tag, "_overload"},    8'(overload),    8'd0);
    chk({tag, "_limit_hit"},   8'(limit_hit),   8'd0);
    chk({tag, "_fault"},       8'(fault),       8'd0);
  endtask

  // One-floor trip; checks motor and at_floor every travel cycle, then landing.
  task automatic travel(input bit up, input logic [1:0] exp_floor);
    move_up   = up;
    move_down = !up;
    step();
    move_up   = 1'b0;
    move_down = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk(up ? "trav_motor_up" : "trav_motor_dn", 8'(up ? motor_up : motor_down), 8'd1);
      chk("trav_at_floor", 8'(at_floor), 8'd0);
      step();
    end
    chk("land_floor",    8'(floor_pos), 8'(exp_floor));
    chk("land_at_floor", 8'(at_floor),  8'd1);
    chk("land_motors",   8'({motor_up, motor_down}), 8'd0);
  endtask

  initial begin
    reset = 1'b1; move_up = 1'b0; move_down = 1'b0; open_door = 1'b0;
    obstruction = 1'b0; load_weight = 8'd0;
    step();
    step();
    reset = 1'b0;
    chk_reset_vals("reset");

    // Travel up one floor: 16 motor cycles, landing on cycle 17.
    travel(1'b1, 2'd1);

    // Uninterrupted door cycle: open 4, hold 8, close 4.
    open_door = 1'b1;
    step();
    open_door = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("door_closed_low", 8'(door_closed),      8'd0);
      chk("door_open_drv",   8'(door_motor_open),  8'(i < 4));
      chk("door_close_drv",  8'(door_motor_close), 8'(i >= 12));
      step();
    end
    chk("door_cycle_done", 8'(door_closed), 8'd1);

    // Obstruction during the second closing cycle.
    open_door = 1'b1;
    step();
    open_door = 1'b0;
    repeat (13) step();
    chk("obs_closing2", 8'(door_motor_close), 8'd1);
    obstruction = 1'b1;
    step();
    obstruction = 1'b0;
`ifdef CAR_DOOR_REVERSAL_EN
    chk("obs_reopen",      8'(door_motor_open), 8'd1);
    chk("obs_still_open",  8'(door_closed),     8'd0);
    begin
      int n = 0;
      while (!door_closed && n < 40) begin
        step();
        n++;
      end
      chk("obs_eventual_close", 8'(door_closed), 8'd1);
    end
`else
    chk("obs_ignored", 8'(door_motor_close), 8'd1);
    step();
    step();
    chk("obs_close_on_time", 8'(door_closed), 8'd1);
`endif

    // Overload boundary and rejection of travel while overloaded.
    load_weight = 8'd201;
    step();
    chk("ovl_201", 8'(overload), 8'd1);
    move_up = 1'b1;
    step();
    move_up = 1'b0;
    chk("ovl_limit_hit", 8'(limit_hit), 8'd1);
    chk("ovl_no_motor",  8'(motor_up),  8'd0);
    load_weight = 8'd200;
    step();
    chk("ovl_pulse_end", 8'(limit_hit), 8'd0);
    chk("ovl_200",       8'(overload),  8'd0);
    chk("ovl_floor",     8'(floor_pos), 8'd1);

    // Back to floor 0, then move_down is rejected.
    travel(1'b0, 2'd0);
    move_down = 1'b1;
    step();
    move_down = 1'b0;
    chk("bot_limit_hit", 8'(limit_hit),  8'd1);
    chk("bot_no_motor",  8'(motor_down), 8'd0);
    chk("bot_floor",     8'(floor_pos),  8'd0);
    step();
    chk("bot_pulse_end", 8'(limit_hit),  8'd0);

    // Up to floor 3, then move_up is rejected.
    travel(1'b1, 2'd1);
    travel(1'b1, 2'd2);
    travel(1'b1, 2'd3);
    move_up = 1'b1;
    step();
    move_up = 1'b0;
    chk("top_limit_hit", 8'(limit_hit), 8'd1);
    chk("top_no_motor",  8'(motor_up),  8'd0);
    chk("top_floor",     8'(floor_pos), 8'd3);
    step();
    chk("top_pulse_end", 8'(limit_hit), 8'd0);

    // Conflicting commands lock the car in fault until reset.
    move_up = 1'b1;
    move_down = 1'b1;
    step();
    move_up = 1'b0;
    move_down = 1'b0;
    chk("flt_fault",  8'(fault), 8'd1);
    chk("flt_motors", 8'({motor_up, motor_down, door_motor_open, door_motor_close}), 8'd0);
    chk("flt_door",   8'(door_closed), 8'd1);
    open_door = 1'b1;
    step();
    open_door = 1'b0;
    move_down = 1'b1;
    step();
    move_down = 1'b0;
    step();
    chk("flt_sticky", 8'(fault), 8'd1);
    chk("flt_sticky_motors",
        8'({motor_up, motor_down, door_motor_open, door_motor_close}), 8'd0);
    chk("flt_floor", 8'(floor_pos), 8'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
